fifo_sync: RTL and testbench
============================

Name: fifo_sync

Overview:
- Synchronous single-clock FIFO that serves as the responder for the FIFO stimulus interface: it accepts write and read strobes, stores data words and returns them in order.
- Provides full/empty and almost-full/almost-empty flags, an occupancy count, and one-cycle overflow/underflow error pulses.
- Sits between a producer driving Fifo_wr/Fifo_Data_in and a consumer driving Fifo_rd.

Parameters:
- BITNUMBER, 8, data word width in bits.
- LENGTH, 8, depth in words; must be a power of two, at least 4.
- ALMOST_FULL_TH, LENGTH-2, Fifo_almost_full asserts when count >= this value.
- ALMOST_EMPTY_TH, 1, Fifo_almost_empty asserts when count <= this value.

Ports:
- clk  input  1  clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- Fifo_wr  input  1  write strobe, sampled on posedge.
- Fifo_rd  input  1  read strobe, sampled on posedge.
- Fifo_Data_in  input  BITNUMBER  write data.
- Fifo_Data_out  output  BITNUMBER  registered read data.
- Fifo_full  output  1  count == LENGTH.
- Fifo_empty  output  1  count == 0.
- Fifo_almost_full  output  1  count >= ALMOST_FULL_TH.
- Fifo_almost_empty  output  1  count <= ALMOST_EMPTY_TH.
- Fifo_count  output  clog2(LENGTH)+1  current occupancy, 0..LENGTH.
- Fifo_overflow  output  1  one-cycle pulse: write rejected.
- Fifo_underflow  output  1  one-cycle pulse: read rejected.

Behaviour:
- Reset (reset=1 at posedge):
  - wr_ptr, rd_ptr, Fifo_count, Fifo_Data_out, Fifo_overflow and Fifo_underflow all go to 0.
  - Fifo_empty=1, Fifo_full=0, Fifo_almost_empty=1, Fifo_almost_full=0.
  - Memory contents are don't-care.
  - Reset has priority over all other inputs, including mid-operation; any stored data is discarded.
- Pointers are clog2(LENGTH) bits wide and wrap modulo LENGTH naturally.
- Flags are combinational decodes of the registered Fifo_count, so they are valid in the same cycle as the count.
- Write: accepted when Fifo_wr=1 and the FIFO is not full (or is full and a read is also accepted this cycle). On acceptance, mem[wr_ptr] <= Fifo_Data_in and wr_ptr increments.
- Read: accepted when Fifo_rd=1 and the FIFO is not empty. On acceptance, Fifo_Data_out <= mem[rd_ptr] and rd_ptr increments.
  - Read latency is 1 cycle: data is valid after the posedge that sampled Fifo_rd.
  - If no read is accepted, Fifo_Data_out holds its previous value.
- Count update per cycle:
  - write only accepted: +1.
  - read only accepted: -1.
  - both accepted, or neither: unchanged.
- Full + rd + wr: both are accepted. Count stays LENGTH, the oldest word is output and the new word is stored. No overflow.
- Full + wr, no rd: write is dropped. Fifo_overflow=1 for exactly one cycle; memory and pointers are unchanged.
- Empty + rd, no wr: read is dropped. Fifo_underflow=1 for one cycle; Fifo_Data_out holds.
- Empty + rd + wr: write is accepted. Read handling depends on FIFO_BYPASS_EN (see Optional Feature).
- Error pulses are registered. They deassert the next cycle unless the condition repeats; back-to-back offending cycles keep the pulse high.

Optional Feature:
- Macro: FIFO_BYPASS_EN.
- Defined: when the FIFO is empty and Fifo_rd and Fifo_wr are both asserted, Fifo_Data_in is passed to Fifo_Data_out on that posedge. Count stays 0, pointers are unchanged, and no underflow is raised.
- Undefined: in the same case the write is stored (count goes to 1), the read is rejected, Fifo_underflow pulses, and Fifo_Data_out holds.

Test Plan:
- Reset: hold reset for 2 cycles with strobes at 0 -> Fifo_empty=1, Fifo_full=0, Fifo_count=0, Fifo_Data_out=0, no error pulses.
- Ordered write/read: write 0xA, 0xB, 0xC, 0xD, then write 0xE with rd=1 -> count goes 1, 2, 3, 4, then stays 4; Fifo_Data_out=0xA the cycle after the read; two further reads -> 0xB, 0xC.
- Fill and overflow: from empty, write 1..8 -> after the 8th write Fifo_full=1 and Fifo_count=8; Fifo_almost_full=1 from count 6. A 9th write of 9 -> Fifo_overflow pulses one cycle. Then 8 reads -> outputs 1..8 in order, Fifo_empty=1 afterwards; the 9 is never seen.
- Full with simultaneous rd+wr: fill with 1..8, then rd=wr=1 with data 9 -> output 1, count stays 8; the next 8 reads return 2..8, 9.
- Underflow and bypass: on an empty FIFO, rd=1 -> Fifo_underflow pulses and Fifo_Data_out holds. With rd=wr=1 and data 0x5: if FIFO_BYPASS_EN is defined, out=0x5 and count=0; otherwise underflow pulses and count=1.
- Mid-operation reset: with count=5, assert reset for 1 cycle -> next cycle count=0, empty=1, out=0. Then write 0x3 and read -> out=0x3.

Source files
------------

// File: rtl/fifo_sync.sv
// rtl/fifo_sync.sv - single-clock FIFO with count, threshold flags and error pulses
// Define FIFO_BYPASS_EN to pass write data straight to the output on read+write while empty.
module fifo_sync #(
  parameter int BITNUMBER       = 8,
  parameter int LENGTH          = 8,
  parameter int ALMOST_FULL_TH  = LENGTH - 2,
  parameter int ALMOST_EMPTY_TH = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       Fifo_wr,
  input  logic                       Fifo_rd,
  input  logic [BITNUMBER-1:0]       Fifo_Data_in,
  output logic [BITNUMBER-1:0]       Fifo_Data_out,
  output logic                       Fifo_full,
  output logic                       Fifo_empty,
  output logic                       Fifo_almost_full,
  output logic                       Fifo_almost_empty,
  output logic [$clog2(LENGTH):0]    Fifo_count,
  output logic                       Fifo_overflow,
  output logic                       Fifo_underflow
);

  localparam int AW = $clog2(LENGTH);
  localparam int CW = AW + 1;

  logic [BITNUMBER-1:0] mem_q [LENGTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [BITNUMBER-1:0] dout_q, dout_d;
  logic                 ovf_q, ovf_d;
  logic                 udf_q, udf_d;
  logic                 full, empty;
  logic                 wr_acc, rd_acc, bypass;

  assign full  = (count_q == CW'(LENGTH));
  assign empty = (count_q == '0);

`ifdef FIFO_BYPASS_EN
  assign bypass = Fifo_rd && Fifo_wr && empty;
`else
  assign bypass = 1'b0;
`endif

  // A full FIFO still takes a write when a read frees a slot in the same cycle.
  assign rd_acc = Fifo_rd && !empty;
  assign wr_acc = Fifo_wr && (!full || rd_acc) && !bypass;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    ovf_d    = Fifo_wr && full && !rd_acc;
    udf_d    = Fifo_rd && empty && !bypass;

    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      dout_d   = mem_q[rd_ptr_q];
    end
    if (bypass) dout_d = Fifo_Data_in;

    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage is not reset; contents are only observable through accepted reads.
  always_ff @(posedge clk) begin
    if (!reset && wr_acc) mem_q[wr_ptr_q] <= Fifo_Data_in;
  end

  assign Fifo_Data_out     = dout_q;
  assign Fifo_count        = count_q;
  assign Fifo_full         = full;
  assign Fifo_empty        = empty;
  assign Fifo_almost_full  = (count_q >= CW'(ALMOST_FULL_TH));
  assign Fifo_almost_empty = (count_q <= CW'(ALMOST_EMPTY_TH));
  assign Fifo_overflow     = ovf_q;
  assign Fifo_underflow    = udf_q;

endmodule

// File: tb/tb_fifo_sync.sv
// tb/tb_fifo_sync.sv - scoreboard bench for fifo_sync with hand-computed expectations
module tb_fifo_sync;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       Fifo_wr = 1'b0;
  logic       Fifo_rd = 1'b0;
  logic [7:0] Fifo_Data_in = 8'h00;
  logic [7:0] Fifo_Data_out;
  logic       Fifo_full, Fifo_empty, Fifo_almost_full, Fifo_almost_empty;
  logic [3:0] Fifo_count;
  logic       Fifo_overflow, Fifo_underflow;

  int vectors = 0;
  int miscompares = 0;
  bit stim_done = 1'b0;

  typedef struct {
    int         cnt;
    logic [7:0] out;
    logic       ovf;
    logic       udf;
  } exp_t;

  exp_t sb[$];

  fifo_sync dut (
    .clk               (clk),
    .reset             (reset),
    .Fifo_wr           (Fifo_wr),
    .Fifo_rd           (Fifo_rd),
    .Fifo_Data_in      (Fifo_Data_in),
    .Fifo_Data_out     (Fifo_Data_out),
    .Fifo_full         (Fifo_full),
    .Fifo_empty        (Fifo_empty),
    .Fifo_almost_full  (Fifo_almost_full),
    .Fifo_almost_empty (Fifo_almost_empty),
    .Fifo_count        (Fifo_count),
    .Fifo_overflow     (Fifo_overflow),
    .Fifo_underflow    (Fifo_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One stimulus cycle; the record describes the DUT state after the next posedge.
  task automatic step(input logic r, input logic w, input logic rd, input logic [7:0] d,
                      input int cnt, input logic [7:0] o, input logic ov, input logic un);
    exp_t e;
    @(negedge clk);
    reset = r; Fifo_wr = w; Fifo_rd = rd; Fifo_Data_in = d;
    e.cnt = cnt; e.out = o; e.ovf = ov; e.udf = un;
    sb.push_back(e);
  endtask

  // Monitor: flags are derived from the expected count using LENGTH=8, thresholds 6 and 1.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("count",        32'(Fifo_count),        32'(e.cnt));
        chk("data_out",     32'(Fifo_Data_out),     32'(e.out));
        chk("overflow",     32'(Fifo_overflow),     32'(e.ovf));
        chk("underflow",    32'(Fifo_underflow),    32'(e.udf));
        chk("full",         32'(Fifo_full),         32'(e.cnt == 8));
        chk("empty",        32'(Fifo_empty),        32'(e.cnt == 0));
        chk("almost_full",  32'(Fifo_almost_full),  32'(e.cnt >= 6));
        chk("almost_empty", 32'(Fifo_almost_empty), 32'(e.cnt <= 1));
      end
    end
  end

  initial begin
    // reset, two cycles
    step(1, 0, 0, 8'h00, 0, 8'h00, 0, 0);
    step(1, 0, 0, 8'h00, 0, 8'h00, 0, 0);

    // ordered write/read, then drain
    step(0, 1, 0, 8'h0A, 1, 8'h00, 0, 0);
    step(0, 1, 0, 8'h0B, 2, 8'h00, 0, 0);
    step(0, 1, 0, 8'h0C, 3, 8'h00, 0, 0);
    step(0, 1, 0, 8'h0D, 4, 8'h00, 0, 0);
    step(0, 1, 1, 8'h0E, 4, 8'h0A, 0, 0);
    step(0, 0, 1, 8'h00, 3, 8'h0B, 0, 0);
    step(0, 0, 1, 8'h00, 2, 8'h0C, 0, 0);
    step(0, 0, 1, 8'h00, 1, 8'h0D, 0, 0);
    step(0, 0, 1, 8'h00, 0, 8'h0E, 0, 0);

    // fill 1..8, overflow with 9, drain 1..8
    for (int i = 1; i <= 8; i++) step(0, 1, 0, 8'(i), i, 8'h0E, 0, 0);
    step(0, 1, 0, 8'h09, 8, 8'h0E, 1, 0);
    for (int i = 1; i <= 8; i++) step(0, 0, 1, 8'h00, 8 - i, 8'(i), 0, 0);

    // full with simultaneous read and write
    for (int i = 1; i <= 8; i++) step(0, 1, 0, 8'(i), i, 8'h08, 0, 0);
    step(0, 1, 1, 8'h09, 8, 8'h01, 0, 0);
    for (int i = 2; i <= 9; i++) step(0, 0, 1, 8'h00, 9 - i, 8'(i), 0, 0);

    // back-to-back underflow, then read+write on empty
    step(0, 0, 1, 8'h00, 0, 8'h09, 0, 1);
    step(0, 0, 1, 8'h00, 0, 8'h09, 0, 1);
`ifdef FIFO_BYPASS_EN
    step(0, 1, 1, 8'h05, 0, 8'h05, 0, 0);
`else
    step(0, 1, 1, 8'h05, 1, 8'h09, 0, 1);
    step(0, 0, 1, 8'h00, 0, 8'h05, 0, 0);
`endif

    // mid-operation reset with a write strobe asserted; reset wins
    for (int i = 1; i <= 5; i++) step(0, 1, 0, 8'(8'h10 + i), i, 8'h05, 0, 0);
    step(1, 1, 1, 8'h77, 0, 8'h00, 0, 0);
    step(0, 1, 0, 8'h03, 1, 8'h00, 0, 0);
    step(0, 0, 1, 8'h00, 0, 8'h03, 0, 0);

    @(negedge clk);
    reset = 1'b0; Fifo_wr = 1'b0; Fifo_rd = 1'b0; Fifo_Data_in = 8'h00;
    stim_done = 1'b1;
  end

  initial begin
    int guard;
    guard = 0;
    wait (stim_done);
    while (sb.size() > 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() > 0) begin
      miscompares++;
      $display("FAIL drain_timeout actual=%0d pending expected=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule
